// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants.
// Shared by vga_timing_gen and its counter.
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT +
    DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT +
    DEF_V_SYNC + DEF_V_BACK;

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter: modulo-N counter with enable,
// wrap pulse and configurable reset value.
module mod_counter #(
  parameter int W       = 10,
  parameter int N       = 800,
  parameter int RST_VAL = N - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] RSTV = W'(RST_VAL);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);

  always_comb begin
    w_next = r_count;
    if (i_en) begin
      w_next = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= RSTV;
    else        r_count <= w_next;
  end

  assign o_count = r_count;
  assign o_next  = w_next;
  assign o_wrap  = i_en && w_at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster position, sync, blank and strobes.
// Optional frame counter: define VGA_FRAME_COUNTER_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [POS_W-1:0] frame_count
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [POS_W-1:0] H_VIS =
    POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] V_VIS =
    POS_W'(V_VISIBLE);
  localparam logic [POS_W-1:0] HS_BEG =
    POS_W'(H_VISIBLE + H_FRONT);
  localparam logic [POS_W-1:0] HS_END =
    POS_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [POS_W-1:0] VS_BEG =
    POS_W'(V_VISIBLE + V_FRONT);
  localparam logic [POS_W-1:0] VS_END =
    POS_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [POS_W-1:0] w_h_nxt;
  logic [POS_W-1:0] w_v_nxt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de_nxt;

  logic r_hsync;
  logic r_vsync;
  logic r_de;
  logic r_ls;
  logic r_fs;

  mod_counter #(
    .W       (POS_W),
    .N       (H_TOTAL),
    .RST_VAL (H_TOTAL - 1)
  ) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (1'b1),
    .o_count (hpos),
    .o_next  (w_h_nxt),
    .o_wrap  (w_h_wrap)
  );

  mod_counter #(
    .W       (POS_W),
    .N       (V_TOTAL),
    .RST_VAL (V_TOTAL - 1)
  ) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_h_wrap),
    .o_count (vpos),
    .o_next  (w_v_nxt),
    .o_wrap  (w_v_wrap)
  );

  // decode the upcoming position so flags line up with hpos/vpos
  assign w_hs_act = (w_h_nxt >= HS_BEG) &&
                    (w_h_nxt <  HS_END);
  assign w_vs_act = (w_v_nxt >= VS_BEG) &&
                    (w_v_nxt <  VS_END);
  assign w_de_nxt = (w_h_nxt < H_VIS) &&
                    (w_v_nxt < V_VIS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= SYNC_ACTIVE_LOW;
      r_vsync <= SYNC_ACTIVE_LOW;
      r_de    <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_hsync <= w_hs_act ^ SYNC_ACTIVE_LOW;
      r_vsync <= w_vs_act ^ SYNC_ACTIVE_LOW;
      r_de    <= w_de_nxt;
      r_ls    <= w_h_wrap;
      r_fs    <= w_v_wrap;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_de;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

`ifdef VGA_FRAME_COUNTER_EN
  logic [POS_W-1:0] r_frame_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= '0;
    end else if (w_v_wrap) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on default,
// reduced and minimal raster configurations.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNTER_EN
  localparam bit FCEN = 1'b1;
`else
  localparam bit FCEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] dh, dv, dfc;
  logic       dhs, dvs, dde, dls, dfs;
  logic [9:0] sh, sv, sfc;
  logic       shs, svs, sde, sls, sfs;
  logic [9:0] th, tv, tfc;
  logic       ths, tvs, tde, tls, tfs;

  vga_timing_gen u_def (
    .clk         (clk),
    .rst_n       (rst_n),
    .hpos        (dh),
    .vpos        (dv),
    .hsync       (dhs),
    .vsync       (dvs),
    .display_on  (dde),
    .line_start  (dls),
    .frame_start (dfs),
    .frame_count (dfc)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2),
    .H_SYNC    (2), .H_BACK  (2),
    .V_VISIBLE (4), .V_FRONT (1),
    .V_SYNC    (1), .V_BACK  (1),
    .SYNC_ACTIVE_LOW (1'b0)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .hpos        (sh),
    .vpos        (sv),
    .hsync       (shs),
    .vsync       (svs),
    .display_on  (sde),
    .line_start  (sls),
    .frame_start (sfs),
    .frame_count (sfc)
  );

  vga_timing_gen #(
    .H_VISIBLE (1), .H_FRONT (1),
    .H_SYNC    (1), .H_BACK  (1),
    .V_VISIBLE (1), .V_FRONT (1),
    .V_SYNC    (1), .V_BACK  (1)
  ) u_tiny (
    .clk         (clk),
    .rst_n       (rst_n),
    .hpos        (th),
    .vpos        (tv),
    .hsync       (ths),
    .vsync       (tvs),
    .display_on  (tde),
    .line_start  (tls),
    .frame_start (tfs),
    .frame_count (tfc)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic chk_rst_vals(input string pfx);
    check({pfx, " hpos"}, 32'(dh), 799);
    check({pfx, " vpos"}, 32'(dv), 524);
    check({pfx, " hsync"}, 32'(dhs), 1);
    check({pfx, " vsync"}, 32'(dvs), 1);
    check({pfx, " de"}, 32'(dde), 0);
    check({pfx, " ls"}, 32'(dls), 0);
    check({pfx, " fs"}, 32'(dfs), 0);
    check({pfx, " fc"}, 32'(dfc), 0);
  endtask

  task automatic chk_first(input string pfx);
    check({pfx, " hpos0"}, 32'(dh), 0);
    check({pfx, " vpos0"}, 32'(dv), 0);
    check({pfx, " de0"}, 32'(dde), 1);
    check({pfx, " ls0"}, 32'(dls), 1);
    check({pfx, " fs0"}, 32'(dfs), 1);
    check({pfx, " fc0"}, 32'(dfc),
          FCEN ? 32'd1 : 32'd0);
  endtask

  initial begin
    int n_hs, hs_first, hs_last;
    int n_de, de_drop;
    int n_vs, vs_line, n_ls, n_fs;

    // power-on reset, 5 clocks
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_rst_vals("rst");
    check("s rst hpos", 32'(sh), 13);
    check("s rst vpos", 32'(sv), 6);
    check("s rst hsync", 32'(shs), 0);
    check("s rst vsync", 32'(svs), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_first("rel");

    // one full line on the default raster
    n_hs = 0; hs_first = -1; hs_last = -1;
    n_de = 0; de_drop = -1;
    for (int i = 0; i < 800; i++) begin
      if (!dhs) begin
        n_hs++;
        if (hs_first < 0) hs_first = int'(dh);
        hs_last = int'(dh);
      end
      if (dde) n_de++;
      else if (de_drop < 0) de_drop = int'(dh);
      step(1);
    end
    check("hs width", n_hs, 96);
    check("hs first", hs_first, 656);
    check("hs last", hs_last, 751);
    check("de count", n_de, 640);
    check("de drop", de_drop, 640);
    check("wrap hpos", 32'(dh), 0);
    check("wrap vpos", 32'(dv), 1);
    check("wrap ls", 32'(dls), 1);
    check("wrap fs", 32'(dfs), 0);
    check("wrap vs", 32'(dvs), 1);

    // asynchronous reset mid-line
    step(1100);
    check("mid hpos", 32'(dh), 300);
    check("mid vpos", 32'(dv), 2);
    #2 rst_n = 1'b0;
    #1 chk_rst_vals("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
    chk_first("resume");

    // reduced raster: 14 x 7, active-high sync
    check("s hpos0", 32'(sh), 0);
    check("s vpos0", 32'(sv), 0);
    check("s fs0", 32'(sfs), 1);
    n_hs = 0; hs_first = -1; n_de = 0;
    n_vs = 0; vs_line = -1; n_ls = 0; n_fs = 0;
    for (int i = 0; i < 98; i++) begin
      if (shs && sv == 0) begin
        n_hs++;
        if (hs_first < 0) hs_first = int'(sh);
      end
      if (svs) begin
        n_vs++;
        vs_line = int'(sv);
      end
      if (sde) n_de++;
      if (sls) n_ls++;
      if (sfs) n_fs++;
      step(1);
    end
    check("s hs width", n_hs, 2);
    check("s hs first", hs_first, 10);
    check("s vs clks", n_vs, 14);
    check("s vs line", vs_line, 5);
    check("s de count", n_de, 32);
    check("s ls count", n_ls, 7);
    check("s fs count", n_fs, 1);
    check("s period fs", 32'(sfs), 1);
    check("s period h", 32'(sh), 0);
    check("s period v", 32'(sv), 0);
    check("s fc 2", 32'(sfc),
          FCEN ? 32'd2 : 32'd0);
    step(98);
    check("s fc 3", 32'(sfc),
          FCEN ? 32'd3 : 32'd0);

    // minimal raster: 16 clks/frame, counter wrap
    step(1022 * 16 - cyc);
    check("t fc 1023", 32'(tfc),
          FCEN ? 32'd1023 : 32'd0);
    check("t fs", 32'(tfs), 1);
    step(15);
    check("t fc hold", 32'(tfc),
          FCEN ? 32'd1023 : 32'd0);
    step(1);
    check("t fc wrap", 32'(tfc), 0);
    check("t fs wrap", 32'(tfs), 1);
    check("d fc", 32'(dfc),
          FCEN ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator for the VGA output path: produces horizontal/vertical position, sync pulses, blanking and frame/line strobes for a 640x480@60 Hz raster from a single ~25.175 MHz pixel clock. It sits directly upstream of the pattern/colour stage that drives the TinyVGA PMOD, which consumes position, display-enable and sync each cycle. It also supplies a clock-domain-clean frame counter, so downstream animation never has to be clocked from vsync.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 while active

Ports:
- clk  input  1  pixel clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- hpos  output  10  current pixel column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- display_on  output  1  high when hpos < H_VISIBLE and vpos < V_VISIBLE
- line_start  output  1  one-cycle pulse when hpos == 0
- frame_start  output  1  one-cycle pulse when hpos == 0 and vpos == 0
- frame_count  output  10  frames completed since reset (see Configuration)

## Operation
- H_TOTAL = sum of H_* (800 by default), V_TOTAL = sum of V_* (525 by default). Both must fit in 10 bits.
- hpos increments every clk and wraps H_TOTAL-1 -> 0. vpos increments on each hpos wrap, and wraps V_TOTAL-1 -> 0 when both counters are at their maximum.
- hsync is active for hpos in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; default [656, 751].
- vsync is active for vpos in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]; default [490, 491]. vsync is line-granular and changes only at an hpos wrap.
- All outputs are registered. Sync, display_on and strobes are decoded from the next counter values, so every output describes the same pixel as the hpos/vpos presented in that cycle.
- Reset (async assert, sync-released by the clk edge) loads the last pixel of the frame:
  - hpos=H_TOTAL-1 (799), vpos=V_TOTAL-1 (524)
  - hsync and vsync inactive (1 when SYNC_ACTIVE_LOW)
  - display_on=0, line_start=0, frame_start=0, frame_count=0
- First clk edge after rst_n rises: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: all outputs return immediately (asynchronously) to the reset values above, and the raster restarts from (0,0) on release.

## Timing
- Latency from counter to decoded outputs is 0 cycles; they are aligned in the same cycle.
- Line period = H_TOTAL clks. Frame period = H_TOTAL*V_TOTAL clks (420000 by default).
- line_start fires V_TOTAL times per frame. frame_start fires once per frame, coincident with a line_start.
- There is no handshake. The downstream stage samples every cycle, and colour must be forced to 0 when display_on=0.

## Configuration
- VGA_FRAME_COUNTER_EN defined:
  - frame_count increments by 1 on every cycle where frame_start is asserted, including the first one after reset, so frame 0 reads 1.
  - Width is 10 bits; it wraps 1023 -> 0.
- VGA_FRAME_COUNTER_EN undefined:
  - frame_count is constant 0 and no counter register is built.
  - The port remains, so the interface is unchanged.

## Structure
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants (the eight porch/sync/visible values)
  - derived H_TOTAL/V_TOTAL
  - the 10-bit position width constant
- One sub-module, mod_counter: a parameterised modulo-N counter with enable, a wrap-out pulse and a configurable reset value. It is instantiated twice: the horizontal instance is always enabled, and the vertical instance is enabled by the horizontal wrap.

## Test plan
- Reset release: hold rst_n=0 for 5 clks, then release. During reset hpos=799, vpos=524, hsync=vsync=1, display_on=0. The first edge after release gives hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1.
- Horizontal timing: run 1 line. hsync=0 exactly for hpos 656..751 (96 clks). display_on drops at hpos=640. hpos wraps 799->0 with vpos +1 and line_start=1.
- Vertical timing: run 1 full frame (420000 clks). vsync=0 for exactly 2 lines (vpos 490, 491, 1600 clks). display_on=0 for vpos >= 480. The next frame_start comes exactly 420000 clks after the previous one.
- Frame counter with VGA_FRAME_COUNTER_EN:
  - After 3 frame_start pulses, frame_count=3.
  - Force 1024 frames, or preload via a shortened-timing parameter set: frame_count wraps 1023->0.
  - Without the macro, frame_count stays 0 throughout.
- Mid-frame reset: assert rst_n=0 asynchronously at hpos=300, vpos=200 (between edges). Outputs go to the reset values without waiting for clk, and the raster resumes at (0,0) on the first edge after release.
- Parameter override: H_VISIBLE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1, SYNC_ACTIVE_LOW=0. Frame = 14*7 = 98 clks. hsync=1 for hpos 10..11. vsync=1 for vpos 5.
